vec_accum_ctrl: RTL and testbench

VEC_ACCUM_CTRL -- requirements
Module: vec_accum_ctrl

---
 rtl/vec_accum_ctrl.sv | 155 +++++++++++++++
 tb/tb_vec_accum_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_accum_ctrl.sv
// rtl/vec_accum_ctrl.sv - job controller sequencing an external vector accumulator
//
// Purpose:
//    Accepts a job (start + vec_len), clears an external accumulator, streams
//    vec_len elements into it, captures the final sum and holds it until the
//    consumer accepts it. Flags an unsigned carry-out seen on any beat of the job.
//
// Ports:
//    clk, rst            clock; asynchronous active-high reset
//    start, vec_len      job request and element count (sampled in IDLE only)
//    busy                high whenever a job is in flight (state != IDLE)
//    in_valid, in_data   element stream in
//    in_ready            element accepted when in_valid & in_ready (RUN only)
//    acc_data, acc_load  accumulator addend and load enable (combinational)
//    acc_clr             registered one-cycle accumulator clear
//    acc_sum             current accumulator register value
//    result, result_valid, result_ready   final sum handshake
//    ovf                 sticky carry-out flag for the current job

module vec_accum_ctrl #(
   parameter int WORD_SIZE = 24,
   parameter int LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     vec_len,
   output logic                 busy,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_data,
   output logic                 in_ready,
   output logic [WORD_SIZE-1:0] acc_data,
   output logic                 acc_load,
   output logic                 acc_clr,
   input  logic [WORD_SIZE-1:0] acc_sum,
   output logic [WORD_SIZE-1:0] result,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 ovf
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic                 clr_q, clr_d;
   logic [WORD_SIZE-1:0] result_q, result_d;
   logic                 ovf_q, ovf_d;

   logic                 beat;
   logic                 last_beat;
   logic [WORD_SIZE:0]   sum_ext;

   // The accumulator itself lives outside; this block only steers it.
   assign in_ready     = (state_q == S_RUN);
   assign beat         = in_valid & in_ready;
   assign acc_load     = beat;
   assign acc_data     = in_data;
   assign acc_clr      = clr_q;
   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign result       = result_q;
   assign ovf          = ovf_q;

   // One extra bit exposes the carry of the addition the accumulator is
   // about to perform on this beat.
   assign sum_ext   = {1'b0, acc_sum} + {1'b0, in_data};

   // len_q is never zero in RUN, so len_q-1 cannot underflow, and the counter
   // tops out at len_q itself, which fits LEN_W bits even for the maximum length.
   assign last_beat = (cnt_q == (len_q - LEN_W'(1)));

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      clr_d    = 1'b0;
      result_d = result_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ovf_d = 1'b0;
               cnt_d = '0;
               if (vec_len != '0) begin
                  len_d   = vec_len;
                  clr_d   = 1'b1;
                  state_d = S_CLEAR;
               end else begin
                  // Empty job: report zero without touching the accumulator.
                  result_d = '0;
                  state_d  = S_DONE;
               end
            end
         end

         S_CLEAR: begin
            state_d = S_RUN;
         end

         S_RUN: begin
            if (beat) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (sum_ext[WORD_SIZE]) begin
                  ovf_d = 1'b1;
               end
               if (last_beat) begin
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            // acc_sum now reflects the last beat loaded on the previous edge.
            result_d = acc_sum;
            state_d  = S_DONE;
         end

         S_DONE: begin
            if (result_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         clr_q    <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         clr_q    <= clr_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_vec_accum_ctrl.sv
// tb/tb_vec_accum_ctrl.sv - randomized self-checking bench for vec_accum_ctrl

module tb_vec_accum_ctrl;

   localparam int W  = 24;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] vec_len;
   logic          busy;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic [W-1:0]  acc_data;
   logic          acc_load;
   logic          acc_clr;
   logic [W-1:0]  acc_sum;
   logic [W-1:0]  result;
   logic          result_valid;
   logic          result_ready;
   logic          ovf;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] job_data[$];

   always #5 clk = ~clk;

   vec_accum_ctrl #(.WORD_SIZE(W), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .acc_data(acc_data), .acc_load(acc_load), .acc_clr(acc_clr),
      .acc_sum(acc_sum), .result(result), .result_valid(result_valid),
      .result_ready(result_ready), .ovf(ovf)
   );

   // External accumulator the controller drives.
   always @(posedge clk or posedge rst) begin
      if (rst)           acc_sum <= '0;
      else if (acc_clr)  acc_sum <= '0;
      else if (acc_load) acc_sum <= acc_sum + acc_data;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Runs one job over job_data. gap = idle cycles forced after each accepted
   // beat, pct = chance in_valid is offered, hold = DONE cycles before acceptance,
   // exp_fixed = directed result_valid cycle (0 = use the model only).
   task automatic run_job(input int gap, input int pct, input int hold, input int exp_fixed);
      int           n, k, c, c_last, c_done, idle_left, loads, exp_done;
      logic [W:0]   t;
      logic [W-1:0] exp_sum;
      logic         exp_ovf, exp_rdy;

      n = job_data.size();
      exp_sum = '0;
      exp_ovf = 1'b0;
      foreach (job_data[i]) begin
         t = {1'b0, exp_sum} + {1'b0, job_data[i]};
         if (t >= (1 << W)) exp_ovf = 1'b1;
         exp_sum = t[W-1:0];
      end

      @(posedge clk); #1;
      start = 1'b1; vec_len = LW'(n); in_valid = 1'b0; result_ready = 1'b0;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      k = 0; c_last = 0; c_done = 0; idle_left = 0; loads = 0;
      for (c = 1; c < 2000 && c_done == 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (idle_left > 0) begin
            in_valid = 1'b0;
            idle_left--;
         end else if (k < n) begin
            in_valid = ($urandom_range(0, 99) < pct);
         end else begin
            in_valid = 1'($urandom_range(0, 1));
         end
         in_data = (k < n) ? job_data[k] : W'($urandom);
         @(negedge clk);
         exp_rdy = (n != 0) && (c >= 2) && (k < n);
         check("busy", {31'd0, busy}, 32'd1);
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         check("acc_load", {31'd0, acc_load}, {31'd0, exp_rdy & in_valid});
         check("acc_clr", {31'd0, acc_clr}, {31'd0, (n != 0) && (c == 1)});
         if (acc_load) loads++;
         if (exp_rdy && in_valid) begin
            check("acc_data", {8'd0, acc_data}, {8'd0, in_data});
            k++;
            idle_left = gap;
            if (k == n) c_last = c;
         end
         if (result_valid) c_done = c;
      end

      exp_done = (n == 0) ? 1 : c_last + 2;
      check("rv_cycle", c_done, exp_done);
      if (exp_fixed != 0) check("rv_directed", c_done, exp_fixed);
      check("load_count", loads, n);
      check("result", {8'd0, result}, {8'd0, exp_sum});
      check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});

      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         start = (h == 1); vec_len = LW'(5); in_valid = 1'b1;
         @(negedge clk);
         check("hold_rv", {31'd0, result_valid}, 32'd1);
         check("hold_result", {8'd0, result}, {8'd0, exp_sum});
         check("hold_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
         check("hold_clr", {31'd0, acc_clr}, 32'd0);
         check("hold_ready", {31'd0, in_ready}, 32'd0);
      end

      // Acceptance cycle with start asserted: must not launch a new job.
      @(posedge clk); #1;
      result_ready = 1'b1; start = 1'b1; vec_len = LW'(3); in_valid = 1'b0;
      @(negedge clk);
      check("accept_rv", {31'd0, result_valid}, 32'd1);
      @(posedge clk); #1;
      result_ready = 1'b0; start = 1'b0;
      @(negedge clk);
      check("post_rv", {31'd0, result_valid}, 32'd0);
      check("post_busy", {31'd0, busy}, 32'd0);
      check("post_clr", {31'd0, acc_clr}, 32'd0);
      check("post_result", {8'd0, result}, {8'd0, exp_sum});
   endtask

   task automatic fill_random(input int n);
      job_data.delete();
      for (int i = 0; i < n; i++) job_data.push_back(W'($urandom));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0;
      in_data = '0; result_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rv", {31'd0, result_valid}, 32'd0);
      check("rst_result", {8'd0, result}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_clr", {31'd0, acc_clr}, 32'd0);
      rst = 1'b0;

      // Basic four-element job.
      job_data = '{24'd1, 24'd2, 24'd3, 24'd4};
      run_job(0, 100, 0, 7);

      // Two idle cycles between beats.
      job_data = '{24'd10, 24'd20, 24'd30};
      run_job(2, 100, 0, 10);

      // Carry out, then a clean job clears ovf.
      job_data = '{24'hFFFFFF, 24'h000002};
      run_job(0, 100, 0, 0);
      job_data = '{24'd1, 24'd2};
      run_job(0, 100, 0, 0);

      // Empty job.
      job_data.delete();
      run_job(0, 100, 2, 1);

      // Consumer back-pressure with start pulsed during DONE.
      fill_random(6);
      run_job(0, 80, 5, 0);

      // Random jobs.
      for (int j = 0; j < 10; j++) begin
         fill_random($urandom_range(1, 20));
         run_job($urandom_range(0, 2), $urandom_range(40, 100), $urandom_range(0, 3), 0);
      end

      // Maximum length completes without counter wrap.
      fill_random(255);
      run_job(0, 90, 1, 0);

      // Leave a nonzero result before the reset test.
      job_data = '{24'd1, 24'd2, 24'd3, 24'd4};
      run_job(0, 100, 0, 7);

      // Reset during RUN after two of five beats.
      @(posedge clk); #1;
      start = 1'b1; vec_len = LW'(5); in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 24'hFFFFFF;
      @(posedge clk); #1;
      in_data = 24'h000002;
      @(posedge clk); #1;
      in_data = 24'h000003;
      check("pre_rst_ovf", {31'd0, ovf}, 32'd1);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_load", {31'd0, acc_load}, 32'd0);
      check("mid_rst_clr", {31'd0, acc_clr}, 32'd0);
      check("mid_rst_result", {8'd0, result}, 32'd0);
      check("mid_rst_rv", {31'd0, result_valid}, 32'd0);
      check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("after_rst_busy", {31'd0, busy}, 32'd0);
         check("after_rst_rv", {31'd0, result_valid}, 32'd0);
         check("after_rst_load", {31'd0, acc_load}, 32'd0);
      end
      in_valid = 1'b0;

      // A fresh job works after reset.
      fill_random(5);
      run_job(1, 100, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
